// File: rtl/write_pkg.sv
// rtl/write_pkg.sv - shared FSM state type and word-geometry helpers for the pixel write engine
package write_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic int lanes_of(input int data_width, input int pixel_size);
    return data_width / pixel_size;
  endfunction

  function automatic int bytes_of(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/pixel_packer.sv
// rtl/pixel_packer.sv - packs pixels MSB-lane first into a word and tracks which bytes are filled
module pixel_packer
  import write_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int PIXEL_SIZE = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    load,
  input  logic [PIXEL_SIZE-1:0]   pixel,
  output logic [DATA_WIDTH-1:0]   packed_word,
  output logic [DATA_WIDTH/8-1:0] byte_mask,
  output logic                    word_full,
  output logic                    pending
);

  localparam int LANES      = lanes_of(DATA_WIDTH, PIXEL_SIZE);
  localparam int LANE_BYTES = PIXEL_SIZE / 8;
  localparam int LW         = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LW-1:0] MSB_LANE = LW'(LANES - 1);

  logic [LW-1:0]         lane;
  logic [DATA_WIDTH-1:0] acc;
  logic [DATA_WIDTH-1:0] pixel_ext;

  assign pixel_ext = DATA_WIDTH'(pixel);

  // Outputs include the pixel loaded this cycle, so a full or flushed word can be written without a bubble.
  always_comb begin
    packed_word = acc;
    if (load) begin
      packed_word = acc | (pixel_ext << (int'(lane) * PIXEL_SIZE));
    end
    byte_mask = '0;
    for (int i = 0; i < LANES; i++) begin
      for (int b = 0; b < LANE_BYTES; b++) begin
        byte_mask[i*LANE_BYTES + b] = load ? (i >= int'(lane)) : (i > int'(lane));
      end
    end
  end

  assign word_full = load && (lane == '0);
  assign pending   = !word_full && (load || (lane != MSB_LANE));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lane <= MSB_LANE;
      acc  <= '0;
    end else if (clear) begin
      lane <= MSB_LANE;
      acc  <= '0;
    end else if (load) begin
      if (lane == '0) begin
        lane <= MSB_LANE;
        acc  <= '0;
      end else begin
        lane <= lane - LW'(1);
        acc  <= packed_word;
      end
    end
  end

endmodule

// File: rtl/pixel_write_engine.sv
// rtl/pixel_write_engine.sv - streams pixels into packed BRAM word writes with byte strobes
module pixel_write_engine
  import write_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int PIXEL_SIZE = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   base_addr,
  input  logic [CNT_WIDTH-1:0]    num_pixels,
  input  logic [PIXEL_SIZE-1:0]   pixel,
  input  logic                    pixel_valid,
  output logic                    pixel_ready,
  input  logic                    flush,
  output logic [ADDR_WIDTH-1:0]   bram_addr,
  output logic [DATA_WIDTH-1:0]   bram_data,
  output logic [DATA_WIDTH/8-1:0] write_enable,
  output logic                    busy,
  output logic                    done,
  output logic [CNT_WIDTH-1:0]    words_written
);

  localparam int BYTES = bytes_of(DATA_WIDTH);

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   word_addr;
  logic [CNT_WIDTH-1:0]    target;
  logic [CNT_WIDTH-1:0]    accepted;
  logic                    xfer;
  logic                    accept_start;
  logic                    job_end;
  logic                    write_go;
  logic [DATA_WIDTH-1:0]   packed_word;
  logic [BYTES-1:0]        byte_mask;
  logic                    word_full;
  logic                    pending;

  assign pixel_ready  = (state == ST_RUN);
  assign xfer         = pixel_ready && pixel_valid;
  assign accept_start = (state == ST_IDLE) && start;
  assign job_end      = pixel_ready && (flush || (xfer && ((accepted + CNT_WIDTH'(1)) == target)));
  assign write_go     = word_full || (job_end && pending);
  assign busy         = (state != ST_IDLE);
  assign done         = (state == ST_DONE);

  pixel_packer #(
    .DATA_WIDTH (DATA_WIDTH),
    .PIXEL_SIZE (PIXEL_SIZE)
  ) u_packer (
    .clk         (clk),
    .reset       (reset),
    .clear       (accept_start),
    .load        (xfer),
    .pixel       (pixel),
    .packed_word (packed_word),
    .byte_mask   (byte_mask),
    .word_full   (word_full),
    .pending     (pending)
  );

  // Every job leaving RUN passes through FLUSH, the cycle in which its final write is on the bus,
  // so done always lands one cycle after the last write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      word_addr     <= '0;
      target        <= '0;
      accepted      <= '0;
      bram_addr     <= '0;
      bram_data     <= '0;
      write_enable  <= '0;
      words_written <= '0;
    end else begin
      write_enable <= '0;
      if (write_go) begin
        bram_addr     <= word_addr;
        bram_data     <= packed_word;
        write_enable  <= byte_mask;
        word_addr     <= word_addr + ADDR_WIDTH'(BYTES);
        words_written <= words_written + CNT_WIDTH'(1);
      end
      case (state)
        ST_IDLE: begin
          if (start) begin
            word_addr     <= base_addr;
            target        <= num_pixels;
            accepted      <= '0;
            words_written <= '0;
            state         <= (num_pixels == '0) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (xfer) begin
            accepted <= accepted + CNT_WIDTH'(1);
          end
          if (job_end) begin
            state <= ST_FLUSH;
          end
        end
        ST_FLUSH: state <= ST_DONE;
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_write_engine.sv
// tb/tb_pixel_write_engine.sv - directed self-checking bench for pixel_write_engine
module tb_pixel_write_engine;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        start, pixel_valid, flush, pixel_ready, busy, done;
  logic [31:0] base_addr, bram_addr, bram_data;
  logic [15:0] num_pixels, words_written;
  logic [7:0]  pixel;
  logic [3:0]  write_enable;

  logic        start_w, pixel_valid_w, flush_w, pixel_ready_w, busy_w, done_w;
  logic [31:0] base_addr_w, bram_addr_w, bram_data_w;
  logic [15:0] num_pixels_w, words_written_w, pixel_w;
  logic [3:0]  write_enable_w;

  pixel_write_engine u_dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .num_pixels(num_pixels),
    .pixel(pixel), .pixel_valid(pixel_valid), .pixel_ready(pixel_ready), .flush(flush),
    .bram_addr(bram_addr), .bram_data(bram_data), .write_enable(write_enable),
    .busy(busy), .done(done), .words_written(words_written)
  );

  pixel_write_engine #(.PIXEL_SIZE(16)) u_dut16 (
    .clk(clk), .reset(reset), .start(start_w), .base_addr(base_addr_w), .num_pixels(num_pixels_w),
    .pixel(pixel_w), .pixel_valid(pixel_valid_w), .pixel_ready(pixel_ready_w), .flush(flush_w),
    .bram_addr(bram_addr_w), .bram_data(bram_data_w), .write_enable(write_enable_w),
    .busy(busy_w), .done(done_w), .words_written(words_written_w)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] wa [8];
  logic [31:0] wd [8];
  logic [3:0]  wwe [8];
  int          wc [8];
  int          nw, nd, dc, rdy, ev, k;
  logic [15:0] p16 [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Cycle index c counts negedges after the start edge; outputs are sampled before inputs are driven.
  task automatic run_job(input logic [31:0] base, input logic [15:0] n, input int npix,
                         input logic [7:0] first, input int flush_at);
    int i;
    i = 0; nw = 0; nd = 0; dc = -1; rdy = 0;
    @(negedge clk);
    start = 1'b1; base_addr = base; num_pixels = n;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (write_enable != 4'h0 && nw < 8) begin
        wa[nw] = bram_addr; wd[nw] = bram_data; wwe[nw] = write_enable; wc[nw] = c; nw++;
      end
      if (done) begin nd++; dc = c; end
      if (pixel_ready) rdy++;
      if (pixel_ready && i < npix) begin
        pixel = first + 8'(i); pixel_valid = 1'b1; flush = (i == flush_at); i++;
      end else begin
        pixel_valid = 1'b0; flush = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 0; base_addr = 0; num_pixels = 0; pixel = 0; pixel_valid = 0; flush = 0;
    start_w = 0; base_addr_w = 0; num_pixels_w = 0; pixel_w = 0; pixel_valid_w = 0; flush_w = 0;
    repeat (2) @(negedge clk);
    chk("rst_ready", pixel_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_we", write_enable, 0);
    chk("rst_addr", bram_addr, 0);
    chk("rst_data", bram_data, 0);
    chk("rst_words", words_written, 0);
    chk("rst_busy16", busy_w, 0);
    reset = 1'b0;
    @(negedge clk);

    run_job(32'h1000, 16'd8, 8, 8'h01, -1);
    chk("j1_nw", nw, 2);
    chk("j1_a0", wa[0], 32'h1000);
    chk("j1_d0", wd[0], 32'h01020304);
    chk("j1_we0", wwe[0], 4'hF);
    chk("j1_a1", wa[1], 32'h1004);
    chk("j1_d1", wd[1], 32'h05060708);
    chk("j1_we1", wwe[1], 4'hF);
    chk("j1_c0", wc[0], 4);
    chk("j1_c1", wc[1], 8);
    chk("j1_done_c", dc, 9);
    chk("j1_nd", nd, 1);
    chk("j1_rdy", rdy, 8);
    chk("j1_words", words_written, 2);
    chk("j1_busy", busy, 0);

    run_job(32'h1000, 16'd6, 6, 8'hA1, -1);
    chk("j2_nw", nw, 2);
    chk("j2_d0", wd[0], 32'hA1A2A3A4);
    chk("j2_a1", wa[1], 32'h1004);
    chk("j2_d1", wd[1], 32'hA5A60000);
    chk("j2_we1", wwe[1], 4'hC);
    chk("j2_c1", wc[1], 6);
    chk("j2_done_c", dc, 7);
    chk("j2_words", words_written, 2);

    run_job(32'h1000, 16'd8, 8, 8'h01, 2);
    chk("j3_nw", nw, 1);
    chk("j3_a0", wa[0], 32'h1000);
    chk("j3_d0", wd[0], 32'h01020300);
    chk("j3_we0", wwe[0], 4'hE);
    chk("j3_c0", wc[0], 3);
    chk("j3_done_c", dc, 4);
    chk("j3_rdy", rdy, 3);
    chk("j3_words", words_written, 1);

    run_job(32'h1000, 16'd0, 0, 8'h00, -1);
    chk("j4_nw", nw, 0);
    chk("j4_done_c", dc, 0);
    chk("j4_nd", nd, 1);
    chk("j4_rdy", rdy, 0);
    chk("j4_words", words_written, 0);

    @(negedge clk);
    start = 1'b1; base_addr = 32'h3000; num_pixels = 16'd4;
    @(negedge clk);
    start = 1'b0; pixel = 8'h55; pixel_valid = 1'b1;
    @(negedge clk);
    pixel = 8'h56;
    @(negedge clk);
    pixel_valid = 1'b0; reset = 1'b1;
    #1;
    chk("mr_busy", busy, 0);
    chk("mr_ready", pixel_ready, 0);
    chk("mr_done", done, 0);
    chk("mr_we", write_enable, 0);
    chk("mr_addr", bram_addr, 0);
    chk("mr_data", bram_data, 0);
    chk("mr_words", words_written, 0);
    @(negedge clk);
    reset = 1'b0;
    ev = 0;
    for (int c = 0; c < 5; c++) begin
      if (write_enable != 4'h0 || done) ev++;
      @(negedge clk);
    end
    chk("mr_quiet", ev, 0);

    run_job(32'h2000, 16'd4, 4, 8'h11, -1);
    chk("j5_nw", nw, 1);
    chk("j5_a0", wa[0], 32'h2000);
    chk("j5_d0", wd[0], 32'h11121314);
    chk("j5_c0", wc[0], 4);
    chk("j5_done_c", dc, 5);
    chk("j5_words", words_written, 1);

    @(negedge clk);
    start_w = 1'b1; base_addr_w = 32'hFFFF_FFFC; num_pixels_w = 16'd4;
    @(negedge clk);
    start_w = 1'b0;
    nw = 0; dc = -1; k = 0;
    for (int c = 0; c < 20; c++) begin
      if (write_enable_w != 4'h0 && nw < 8) begin
        wa[nw] = bram_addr_w; wd[nw] = bram_data_w; wwe[nw] = write_enable_w; wc[nw] = c; nw++;
      end
      if (done_w) dc = c;
      if (pixel_ready_w && k < 4) begin
        pixel_w = p16[k]; pixel_valid_w = 1'b1; k++;
      end else begin
        pixel_valid_w = 1'b0;
      end
      @(negedge clk);
    end
    chk("w16_nw", nw, 2);
    chk("w16_a0", wa[0], 32'hFFFF_FFFC);
    chk("w16_d0", wd[0], 32'h11112222);
    chk("w16_a1", wa[1], 32'h0000_0000);
    chk("w16_d1", wd[1], 32'h33334444);
    chk("w16_we1", wwe[1], 4'hF);
    chk("w16_c1", wc[1], 4);
    chk("w16_done_c", dc, 5);
    chk("w16_words", words_written_w, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pixel_write_engine.md
PIXEL_WRITE_ENGINE -- requirements
Module: pixel_write_engine

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning BRAM word width in bits (multiple of 8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, meaning BRAM byte-address width.
REQ-003 SHALL have parameter PIXEL_SIZE, default 8, meaning bits per pixel (multiple of 8; must divide DATA_WIDTH).
REQ-004 SHALL have parameter CNT_WIDTH, default 16, meaning width of the pixel-count field.
REQ-005 SHALL have ports: clk in 1, the single clock; reset in 1, asynchronous active-high.
REQ-006 SHALL have ports: start in 1, job launch; base_addr in ADDR_WIDTH, first word byte address; num_pixels in CNT_WIDTH, pixels in the job.
REQ-007 SHALL have ports: pixel in PIXEL_SIZE, input pixel; pixel_valid in 1, pixel present; pixel_ready out 1, engine accepts the pixel.
REQ-008 SHALL have port flush in 1, meaning end the job early and write any partial word.
REQ-009 SHALL have ports: bram_addr out ADDR_WIDTH; bram_data out DATA_WIDTH; write_enable out DATA_WIDTH/8, per-byte strobe.
REQ-010 SHALL have ports: busy out 1, job in progress; done out 1, one-cycle completion pulse; words_written out CNT_WIDTH, words written in the current or last job.

Function
REQ-011 SHALL derive LANES = DATA_WIDTH/PIXEL_SIZE and BYTES = DATA_WIDTH/8.
REQ-012 SHALL implement states IDLE, RUN, FLUSH, DONE.
REQ-013 IDLE: start=1 latches base_addr and num_pixels and moves to RUN; with num_pixels=0 it moves to DONE instead.
REQ-014 SHALL ignore start outside IDLE.
REQ-015 pixel_ready SHALL be 1 only in RUN; a pixel transfers when pixel_valid and pixel_ready are both 1.
REQ-016 SHALL place the first pixel of each word in the most-significant lane, with subsequent pixels in descending lanes.
REQ-017 When a transfer fills the last lane, the next cycle SHALL present bram_addr = current word address, bram_data = packed word, and write_enable = all ones for exactly one cycle.
REQ-018 SHALL keep accepting pixels every cycle during a word write; there are no bubbles at full rate.
REQ-019 SHALL advance the word address by BYTES after each write and increment words_written.
REQ-020 When accepted pixels reach num_pixels, RUN SHALL move to FLUSH if a partial word is pending, otherwise to DONE after the final full write.
REQ-021 flush=1 in RUN SHALL behave as if num_pixels has been reached: any pixel transferred in the same cycle is included first.
REQ-022 FLUSH SHALL write the partial word once: unfilled lanes read as 0, and their write_enable bytes are 0.
REQ-023 DONE SHALL assert done for one cycle, the cycle after the final write, then return to IDLE.
REQ-024 busy SHALL be 1 in RUN, FLUSH and DONE.
REQ-025 words_written SHALL hold its value until the next start and clear on accepted start.
REQ-026 SHALL compute addresses modulo 2^ADDR_WIDTH, wrapping silently.
REQ-027 bram_addr and bram_data SHALL hold their last values while write_enable=0.

Reset
REQ-028 On reset SHALL enter IDLE with pixel_ready=0, busy=0, done=0, write_enable=0, bram_addr=0, bram_data=0, words_written=0, and the lane index at the MSB lane.
REQ-029 Reset mid-job SHALL discard the partial word without writing it and without asserting done.

Structure
REQ-030 SHALL place the state enum and the LANES/BYTES helper functions in shared package write_pkg.
REQ-031 SHALL isolate lane packing, the lane index and the partial-mask generation in sub-module pixel_packer.

Verification
REQ-032 Defaults, base=0x1000, N=8, pixels 0x01..0x08 back-to-back -> writes 0x01020304@0x1000 and 0x05060708@0x1004 with WE=0xF; done one cycle later; words_written=2.
REQ-033 N=6, pixels 0xA1..0xA6 -> second write 0xA5A60000@0x1004 with WE=0xC.
REQ-034 N=8 with flush asserted alongside the 3rd pixel (0x03) -> single write 0x01020300 with WE=0xE; done follows; no further pixel_ready.
REQ-035 num_pixels=0 -> no write; done one cycle after start.
REQ-036 PIXEL_SIZE=16, base=0xFFFF_FFFC, N=4 -> writes at 0xFFFF_FFFC then 0x0000_0000 (wrap).
REQ-037 Reset asserted after 2 of 4 pixels -> no write, no done; a new start then runs normally from base_addr.
